// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake, ALU drive/return and writeback report
// bundle for the alu_issue stage. The stage uses the slave modport; the
// instruction source plus the ALU sit on the master side.
interface alu_issue_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_imm_val;
  logic              alu_imm;
  logic [3:0]        alu_func;
  logic [DATA_W-1:0] alu_out;
  logic              res_valid;
  logic [2:0]        res_rd;
  logic [DATA_W-1:0] res_data;
  logic              illegal;

  modport master (
    output in_valid, in_instr, alu_out,
    input  in_ready, alu_a, alu_b, alu_imm_val, alu_imm, alu_func,
    input  res_valid, res_rd, res_data, illegal
  );

  modport slave (
    input  in_valid, in_instr, alu_out,
    output in_ready, alu_a, alu_b, alu_imm_val, alu_imm, alu_func,
    output res_valid, res_rd, res_data, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: decode/issue slot and writeback around the 16-bit microcpu ALU.
// Holds an 8x16 register file (r0 hardwired to zero). Dependent back-to-back
// instructions are resolved by forwarding alu_out when ALU_FWD_EN is defined,
// otherwise by a one-cycle stall on in_ready.
module alu_issue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 6
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);
  localparam int unsigned NREG     = 8;
  localparam int unsigned RIDX_W   = 3;
  localparam int unsigned FUNC_W   = 4;
  localparam logic [FUNC_W-1:0] FUNC_MAX = FUNC_W'(5);

  // Issue slot and writeback state
  logic              slot_vld_q, slot_vld_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] immv_q, immv_d;
  logic              imm_q, imm_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [RIDX_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic              res_valid_q;
  logic [RIDX_W-1:0] res_rd_q;
  logic [DATA_W-1:0] res_data_q;
  logic              illegal_q;

  // Decode of the incoming word
  logic              is_imm_c;
  logic [RIDX_W-1:0] op_c, rd_c, ra_c, rb_c;
  logic [DATA_W-1:0] imm_ext_c;
  logic [DATA_W-1:0] rf_a_c, rf_b_c, opa_c, opb_c;
  logic              wb_c, dep_a_c, dep_b_c, accept_c;

  assign is_imm_c  = bus.in_instr[15];
  assign op_c      = bus.in_instr[14:12];
  assign rd_c      = bus.in_instr[11:9];
  assign ra_c      = bus.in_instr[8:6];
  assign rb_c      = is_imm_c ? bus.in_instr[8:6] : bus.in_instr[5:3];
  assign imm_ext_c = {{(DATA_W-IMM_W){bus.in_instr[IMM_W-1]}}, bus.in_instr[IMM_W-1:0]};

  // Slot instruction retires (writes back) at the next edge
  assign wb_c = slot_vld_q && (func_q <= FUNC_MAX);

  // Incoming sources that depend on the retiring destination
  assign dep_a_c = wb_c && (rd_q != '0) && !is_imm_c && (ra_c == rd_q);
  assign dep_b_c = wb_c && (rd_q != '0) && (rb_c == rd_q);

  assign rf_a_c = (ra_c == '0) ? '0 : rf_q[ra_c];
  assign rf_b_c = (rb_c == '0) ? '0 : rf_q[rb_c];

`ifdef ALU_FWD_EN
  // Dependent operands take the live ALU result; never stall
  assign bus.in_ready = 1'b1;
  assign opa_c        = dep_a_c ? bus.alu_out : rf_a_c;
  assign opb_c        = dep_b_c ? bus.alu_out : rf_b_c;
`else
  // Hold a dependent instruction one cycle until the writeback has landed
  assign bus.in_ready = !(bus.in_valid && (dep_a_c || dep_b_c));
  assign opa_c        = rf_a_c;
  assign opb_c        = rf_b_c;
`endif

  assign accept_c = bus.in_valid && bus.in_ready;

  // Next slot contents: latch on accept, otherwise empty
  always_comb begin
    slot_vld_d = 1'b0;
    a_d        = '0;
    b_d        = '0;
    immv_d     = '0;
    imm_d      = 1'b0;
    func_d     = '0;
    rd_d       = '0;
    if (accept_c) begin
      slot_vld_d = 1'b1;
      a_d        = is_imm_c ? '0 : opa_c;
      b_d        = opb_c;
      immv_d     = is_imm_c ? imm_ext_c : '0;
      imm_d      = is_imm_c;
      func_d     = {1'b0, op_c};
      rd_d       = rd_c;
    end
  end

  // Issue slot register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      immv_q     <= '0;
      imm_q      <= 1'b0;
      func_q     <= '0;
      rd_q       <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      a_q        <= a_d;
      b_q        <= b_d;
      immv_q     <= immv_d;
      imm_q      <= imm_d;
      func_q     <= func_d;
      rd_q       <= rd_d;
    end
  end

  // Writeback into the register file, result report and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      res_valid_q <= wb_c;
      if (wb_c) begin
        res_rd_q   <= rd_q;
        res_data_q <= bus.alu_out;
        if (rd_q != '0) rf_q[rd_q] <= bus.alu_out;
      end
      if (slot_vld_q && !wb_c) illegal_q <= 1'b1;
    end
  end

  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_imm_val = immv_q;
  assign bus.alu_imm     = imm_q;
  assign bus.alu_func    = func_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_rd      = res_rd_q;
  assign bus.res_data    = res_data_q;
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed stimulus for alu_issue with an architectural
// reference model (sequential register-file semantics) checked every cycle.
module tb_alu_issue;
  localparam int unsigned DW = 16;
`ifdef ALU_FWD_EN
  localparam int STALL_DEP = 0;
`else
  localparam int STALL_DEP = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.DATA_W(DW)) bus();
  alu_issue #(.DATA_W(DW), .IMM_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // 16-bit ALU behaviour
  function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [15:0] a,
                                         input logic [15:0] b);
    case (f)
      4'd0:    return a;
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a * b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      default: return 16'h0000;
    endcase
  endfunction

  // External ALU attached to the stage
  logic [15:0] alu_opa;
  always_comb begin
    alu_opa     = bus.alu_imm ? bus.alu_imm_val : bus.alu_a;
    bus.alu_out = alu_fn(bus.alu_func, alu_opa, bus.alu_b);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one architectural instruction record
  typedef struct packed {
    bit        vld;
    bit        ill;
    bit        imm;
    bit [2:0]  rd;
    bit [3:0]  func;
    bit [15:0] a;
    bit [15:0] b;
    bit [15:0] immv;
    bit [15:0] data;
  } ent_t;

  logic [15:0] ref_rf [8];
  ent_t p0, p1, nw;
  bit   sticky;

  function automatic ent_t exec(input logic [15:0] ins);
    ent_t e;
    logic [2:0] ra, rb;
    e      = '0;
    e.vld  = 1'b1;
    e.imm  = ins[15];
    e.func = {1'b0, ins[14:12]};
    e.rd   = ins[11:9];
    e.ill  = (ins[14:12] > 3'd5);
    if (e.imm) begin
      rb     = ins[8:6];
      e.immv = 16'($signed(ins[5:0]));
    end else begin
      ra  = ins[8:6];
      rb  = ins[5:3];
      e.a = ref_rf[ra];
    end
    e.b    = ref_rf[rb];
    e.data = alu_fn(e.func, e.imm ? e.immv : e.a, e.b);
    return e;
  endfunction

  // A dependent instruction may be held only in the stall build
  function automatic bit exp_ready(input logic [15:0] ins, input logic v, input ent_t s);
    bit dep;
    if (!v || STALL_DEP == 0) return 1'b1;
    dep = s.vld && !s.ill && (s.rd != 3'd0) &&
          ((ins[15] ? ins[8:6] : ins[5:3]) == s.rd || (!ins[15] && ins[8:6] == s.rd));
    return !dep;
  endfunction

  // Per-cycle compare against the model
  initial begin
    p0 = '0; p1 = '0; sticky = 1'b0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        p0 = '0; p1 = '0; sticky = 1'b0;
        for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0;
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_rd", bus.res_rd, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_alu_func", bus.alu_func, 0);
        chk("rst_alu_imm", bus.alu_imm, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_in_ready", bus.in_ready, 1);
      end else begin
        if (p0.vld && p0.ill) sticky = 1'b1;
        chk("res_valid", bus.res_valid, p0.vld && !p0.ill);
        if (p0.vld && !p0.ill) begin
          chk("res_rd", bus.res_rd, p0.rd);
          chk("res_data", bus.res_data, p0.data);
        end
        chk("illegal", bus.illegal, sticky);
        if (p1.vld) begin
          chk("alu_func", bus.alu_func, p1.func);
          chk("alu_imm", bus.alu_imm, p1.imm);
          chk("alu_b", bus.alu_b, p1.b);
          if (p1.imm) chk("alu_imm_val", bus.alu_imm_val, p1.immv);
          else        chk("alu_a", bus.alu_a, p1.a);
        end
        chk("in_ready", bus.in_ready, exp_ready(bus.in_instr, bus.in_valid, p1));
        p0 = p1;
        p1 = '0;
        if (bus.in_valid && bus.in_ready) begin
          nw = exec(bus.in_instr);
          if (!nw.ill && nw.rd != 3'd0) ref_rf[nw.rd] = nw.data;
          p1 = nw;
        end
      end
    end
  end

  // Present an instruction and wait (bounded) until it is accepted
  task automatic issue(input logic [15:0] ins, output int stalls);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    stalls = 0;
    #1;
    while (!bus.in_ready) begin
      stalls++;
      if (stalls > 4) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: instr %0h not accepted after %0d cycles", ins, stalls);
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_instr = 16'h0;
  endtask

  // Literal check of the writeback of the instruction just accepted
  task automatic expect_wb(input string nm, input logic [2:0] rd, input logic [15:0] d);
    idle();
    @(negedge clk); #3;
    chk({nm, "_valid"}, bus.res_valid, 1);
    chk({nm, "_rd"}, bus.res_rd, rd);
    chk({nm, "_data"}, bus.res_data, d);
  endtask

  int s;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("lit_ready_after_rst", bus.in_ready, 1);

    // imm ADD r1 = r0 + 5
    issue(16'h9205, s);
    expect_wb("add_imm", 3'd1, 16'h0005);

    // r1 = -1, then dependent SUB r2 = r0 - r1
    issue(16'h923F, s);
    chk("stall_indep", s, 0);
    issue(16'h2408, s);
    chk("stall_dep_sub", s, STALL_DEP);
    idle();
    repeat (2) @(negedge clk);
    chk("model_r1", ref_rf[1], 16'hFFFF);
    chk("model_r2", ref_rf[2], 16'h0001);

    // r3 = 7, r4 = 9, MUL r5, AND r6, then OR r7
    issue(16'h9607, s);
    issue(16'h9809, s);
    chk("stall_r4", s, 0);
    issue(16'h3AE0, s);
    chk("stall_dep_mul", s, STALL_DEP);
    issue(16'h4CE0, s);
    chk("stall_and", s, 0);
    idle();
    repeat (2) @(negedge clk);
    chk("model_r5", ref_rf[5], 16'h003F);
    chk("model_r6", ref_rf[6], 16'h0001);
    issue(16'h5EE0, s);
    expect_wb("or_r7", 3'd7, 16'h000F);

    // write to r0 is reported but discarded; r1 <- r0 must be zero
    issue(16'h901F, s);
    expect_wb("wr_r0", 3'd0, 16'h001F);
    issue(16'h0200, s);
    expect_wb("rd_r0", 3'd1, 16'h0000);

    // op 6 targeting r3; a following read of r3 is not held and sees 7
    issue(16'h66D8, s);
    issue(16'h00C0, s);
    chk("stall_after_ill", s, 0);
    expect_wb("r3_kept", 3'd0, 16'h0007);
    chk("lit_illegal_set", bus.illegal, 1);
    repeat (2) @(negedge clk);
    #3;
    chk("lit_illegal_sticky", bus.illegal, 1);

    // reset the cycle after accepting ADD r1: nothing must retire
    issue(16'h9205, s);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #3;
    chk("lit_rst_no_wb", bus.res_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("lit_illegal_cleared", bus.illegal, 0);
    issue(16'h0040, s);
    expect_wb("r1_after_rst", 3'd0, 16'h0000);

    idle();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
